// File: rtl/e_mdu_if.sv
// Execute-stage MDU bus: operands and decoded op in, stall flags and HI/LO out.
interface e_mdu_if;
  logic        Req;
  logic [3:0]  MDUOp;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDU_out;

  modport master (
    output Req, MDUOp, E_rs_data, E_rt_data,
    input  Start, Busy, HI, LO, E_MDU_out
  );

  modport slave (
    input  Req, MDUOp, E_rs_data, E_rt_data,
    output Start, Busy, HI, LO, E_MDU_out
  );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers for Execute.
// Define MDU_MADD_EN to decode MADD/MADDU as accumulating multiplies.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res_q, res_d;
  logic        divZero_q, divZero_d;

  logic        isMul, isDiv, isSigned, start, busy;
  logic [63:0] mulA, mulB, product;
  logic [31:0] quo, rem;
`ifdef MDU_MADD_EN
  logic        isAcc;
`endif

  always_comb begin
    isMul    = 1'b0;
    isDiv    = 1'b0;
    isSigned = 1'b0;
`ifdef MDU_MADD_EN
    isAcc    = 1'b0;
`endif
    case (bus.MDUOp)
      OP_MULT:  begin isMul = 1'b1; isSigned = 1'b1; end
      OP_MULTU: isMul = 1'b1;
      OP_DIV:   begin isDiv = 1'b1; isSigned = 1'b1; end
      OP_DIVU:  isDiv = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin isMul = 1'b1; isSigned = 1'b1; isAcc = 1'b1; end
      OP_MADDU: begin isMul = 1'b1; isAcc = 1'b1; end
`endif
      default:  ;
    endcase
  end

  // Operands are widened to 64 bits so one multiplier serves both signednesses.
  always_comb begin
    mulA    = isSigned ? {{32{bus.E_rs_data[31]}}, bus.E_rs_data} : {32'd0, bus.E_rs_data};
    mulB    = isSigned ? {{32{bus.E_rt_data[31]}}, bus.E_rt_data} : {32'd0, bus.E_rt_data};
    product = mulA * mulB;
    quo     = 32'd0;
    rem     = 32'd0;
    if (bus.E_rt_data != 32'd0) begin
      if (isSigned) begin
        quo = 32'($signed(bus.E_rs_data) / $signed(bus.E_rt_data));
        rem = 32'($signed(bus.E_rs_data) % $signed(bus.E_rt_data));
      end else begin
        quo = bus.E_rs_data / bus.E_rt_data;
        rem = bus.E_rs_data % bus.E_rt_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == RUN);
    start         = (isMul || isDiv) && !bus.Req && !busy;
    bus.Busy      = busy;
    bus.Start     = start;
    bus.E_MDU_out = (bus.MDUOp == OP_MFHI) ? hi_q :
                    (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;
  end

  // Result is fixed at start; the busy period only models latency.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_d     = res_q;
    divZero_d = divZero_q;
    if (start) begin
      cnt_d     = isDiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      divZero_d = isDiv && (bus.E_rt_data == 32'd0);
      if (isDiv) res_d = {rem, quo};
`ifdef MDU_MADD_EN
      else if (isAcc) res_d = {hi_q, lo_q} + product;
`endif
      else res_d = product;
    end else if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && !divZero_q) {hi_d, lo_d} = res_q;
    end else if (!bus.Req) begin
      if (bus.MDUOp == OP_MTHI) hi_d = bus.E_rs_data;
      if (bus.MDUOp == OP_MTLO) lo_d = bus.E_rs_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      res_q     <= 64'd0;
      divZero_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_q     <= res_d;
      divZero_q <= divZero_d;
    end
  end

  assign bus.HI = hi_q;
  assign bus.LO = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: arithmetic model checked every cycle plus literal anchors.
module tb_e_mdu;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  e_mdu_if mduIf ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mduIf)
  );

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] mHi, mLo;
  logic [63:0] mPend;
  bit          mPendZero;
  int          edgeCount, doneAt, busyCycles;
  bit          checkEn;

  function automatic bit startClass(logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd4) || (MADD_EN && (op == 4'd9 || op == 4'd10));
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model advances at each rising edge: Busy means the edge count is below the completion edge.
  task automatic modelEdge();
    bit          wasBusy;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    longint      sa, sb;
    int          sd, st;
    logic [63:0] prod;
    op = mduIf.MDUOp;
    rs = mduIf.E_rs_data;
    rt = mduIf.E_rt_data;
    wasBusy = edgeCount < doneAt;
    edgeCount++;
    if (wasBusy) begin
      if (edgeCount == doneAt && !mPendZero) {mHi, mLo} = mPend;
    end else if (!mduIf.Req && startClass(op)) begin
      mPendZero = 1'b0;
      prod = 64'd0;
      if (op == 4'd1 || op == 4'd9) begin
        sa = $signed(rs);
        sb = $signed(rt);
        prod = sa * sb;
      end else if (op == 4'd2 || op == 4'd10) begin
        prod = {32'd0, rs} * {32'd0, rt};
      end
      if (op == 4'd3 || op == 4'd4) begin
        mPendZero = (rt == 32'd0);
        if (!mPendZero) begin
          if (op == 4'd3) begin
            sd = $signed(rs);
            st = $signed(rt);
            mPend = {32'(sd % st), 32'(sd / st)};
          end else begin
            mPend = {rs % rt, rs / rt};
          end
        end
        doneAt = edgeCount + 10;
      end else begin
        mPend = (op >= 4'd9) ? ({mHi, mLo} + prod) : prod;
        doneAt = edgeCount + 5;
      end
    end else if (!mduIf.Req) begin
      if (op == 4'd7) mHi = rs;
      if (op == 4'd8) mLo = rs;
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      logic        expBusy;
      logic        expStart;
      logic [31:0] expOut;
      expBusy  = edgeCount < doneAt;
      expStart = startClass(mduIf.MDUOp) && !mduIf.Req && !expBusy;
      expOut   = (mduIf.MDUOp == 4'd5) ? mHi : (mduIf.MDUOp == 4'd6) ? mLo : 32'd0;
      checkOutput("cycle Busy", mduIf.Busy, expBusy);
      checkOutput("cycle Start", mduIf.Start, expStart);
      checkOutput("cycle HI", mduIf.HI, mHi);
      checkOutput("cycle LO", mduIf.LO, mLo);
      checkOutput("cycle E_MDU_out", mduIf.E_MDU_out, expOut);
      if (mduIf.Busy) busyCycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(logic [3:0] op, logic [31:0] rs, logic [31:0] rt, logic req);
    mduIf.MDUOp     = op;
    mduIf.E_rs_data = rs;
    mduIf.E_rt_data = rt;
    mduIf.Req       = req;
    tick();
  endtask

  task automatic issue(string name, logic [3:0] op, logic [31:0] rs, logic [31:0] rt,
                       logic req, logic expStart);
    mduIf.MDUOp     = op;
    mduIf.E_rs_data = rs;
    mduIf.E_rt_data = rt;
    mduIf.Req       = req;
    #1;
    checkOutput(name, mduIf.Start, expStart);
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    mduIf.MDUOp     = 4'd0;
    mduIf.E_rs_data = 32'd0;
    mduIf.E_rt_data = 32'd0;
    mduIf.Req       = 1'b0;
    mHi = 32'd0; mLo = 32'd0; mPend = 64'd0; mPendZero = 1'b0;
    edgeCount = 0; doneAt = 0; busyCycles = 0; checkEn = 1'b0;
    #2;
    checkOutput("reset Busy", mduIf.Busy, 1'b0);
    checkOutput("reset HI", mduIf.HI, 32'd0);
    checkOutput("reset LO", mduIf.LO, 32'd0);
    checkOutput("reset Start", mduIf.Start, 1'b0);
    checkOutput("reset E_MDU_out", mduIf.E_MDU_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkEn = 1'b1;

    busyCycles = 0;
    issue("mult Start", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    idle(8);
    checkOutput("mult busy cycles", busyCycles, 5);
    checkOutput("mult HI", mduIf.HI, 32'hFFFF_FFFF);
    checkOutput("mult LO", mduIf.LO, 32'hFFFF_FFFA);

    issue("mult neg Start", 4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0, 1'b1);
    idle(8);
    checkOutput("mult neg HI", mduIf.HI, 32'd0);
    checkOutput("mult neg LO", mduIf.LO, 32'd12);

    busyCycles = 0;
    issue("div Start", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    applyStimulus(4'd5, 32'd0, 32'd0, 1'b0);
    idle(12);
    checkOutput("div busy cycles", busyCycles, 10);
    checkOutput("div LO", mduIf.LO, 32'hFFFF_FFFD);
    checkOutput("div HI", mduIf.HI, 32'hFFFF_FFFF);

    issue("divu Start", 4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    idle(12);
    checkOutput("divu LO", mduIf.LO, 32'h7FFF_FFFC);
    checkOutput("divu HI", mduIf.HI, 32'd1);

    busyCycles = 0;
    issue("req multu Start", 4'd2, 32'd5, 32'd7, 1'b1, 1'b0);
    idle(3);
    checkOutput("req busy cycles", busyCycles, 0);
    checkOutput("req HI", mduIf.HI, 32'd1);
    checkOutput("req LO", mduIf.LO, 32'h7FFF_FFFC);

    busyCycles = 0;
    issue("midreq Start", 4'd2, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b1);
    idle(1);
    applyStimulus(4'd2, 32'd1, 32'd1, 1'b1);
    applyStimulus(4'd2, 32'd1, 32'd1, 1'b1);
    idle(5);
    checkOutput("midreq busy cycles", busyCycles, 5);
    checkOutput("midreq HI", mduIf.HI, 32'd6);
    checkOutput("midreq LO", mduIf.LO, 32'd0);

    issue("mtlo Start", 4'd8, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    mduIf.MDUOp = 4'd6;
    #1;
    checkOutput("mflo out", mduIf.E_MDU_out, 32'h1234_5678);
    tick();
    issue("mthi Start", 4'd7, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    mduIf.MDUOp = 4'd5;
    #1;
    checkOutput("mfhi out", mduIf.E_MDU_out, 32'hCAFE_F00D);
    tick();
    issue("mthi req Start", 4'd7, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    idle(1);
    checkOutput("mthi req HI", mduIf.HI, 32'hCAFE_F00D);

    busyCycles = 0;
    issue("div0 Start", 4'd3, 32'd100, 32'd0, 1'b0, 1'b1);
    idle(12);
    checkOutput("div0 busy cycles", busyCycles, 10);
    checkOutput("div0 HI", mduIf.HI, 32'hCAFE_F00D);
    checkOutput("div0 LO", mduIf.LO, 32'h1234_5678);

    issue("rstdiv Start", 4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    idle(2);
    #1;
    reset = 1'b1;
    mHi = 32'd0; mLo = 32'd0; mPend = 64'd0; mPendZero = 1'b0;
    doneAt = edgeCount;
    #1;
    checkOutput("rst mid Busy", mduIf.Busy, 1'b0);
    checkOutput("rst mid HI", mduIf.HI, 32'd0);
    checkOutput("rst mid LO", mduIf.LO, 32'd0);
    #1;
    reset = 1'b0;
    busyCycles = 0;
    idle(12);
    checkOutput("rst after busy cycles", busyCycles, 0);
    checkOutput("rst after HI", mduIf.HI, 32'd0);
    checkOutput("rst after LO", mduIf.LO, 32'd0);

    issue("acc mtlo Start", 4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    busyCycles = 0;
    issue("maddu Start", 4'd10, 32'd1, 32'd1, 1'b0, MADD_EN);
    idle(8);
    checkOutput("maddu busy cycles", busyCycles, MADD_EN ? 5 : 0);
    checkOutput("maddu HI", mduIf.HI, MADD_EN ? 32'd1 : 32'd0);
    checkOutput("maddu LO", mduIf.LO, MADD_EN ? 32'd0 : 32'hFFFF_FFFF);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit with HI/LO for the exception-capable MIPS pipeline. Consumes the operands and instruction the D/E pipeline register hands to Execute. Runs signed/unsigned multiply and divide over a fixed multi-cycle latency and holds the HI/LO architectural registers. Exports `Start` and `Busy` so Decode can stall later HI/LO users. It also gates new work with the exception request, so a victim instruction in Execute never alters HI/LO.

## Interface
- `MULT_CYCLES`, default 5: cycles a MULT/MULTU/MADD/MADDU keeps `Busy` high.
- `DIV_CYCLES`, default 10: cycles a DIV/DIVU keeps `Busy` high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `Req`  in  1  exception/interrupt request; when high, this cycle's E instruction is cancelled.
- `MDUOp`  in  4  decoded op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; 11–15 treated as NONE.
- `E_rs_data`  in  32  forwarded rs operand.
- `E_rt_data`  in  32  forwarded rt operand.
- `Start`  out  1  combinational: `MDUOp` ∈ {1,2,3,4,9,10} and `!Req` and `!Busy`.
- `Busy`  out  1  registered: an operation is in flight.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.
- `E_MDU_out`  out  32  combinational: HI for MFHI, LO for MFLO, else 0.

## Operation
- States: IDLE (counter = 0, `Busy` = 0) and RUN (counter > 0, `Busy` = 1).
- **IDLE, `Start` = 1:**
  - Computes the result from the current operands into 64-bit `res_hi:res_lo`.
  - Loads the counter with `MULT_CYCLES` or `DIV_CYCLES` and enters RUN.
- **Arithmetic:**
  - MULT: `{hi,lo}` = signed 32×32 → 64.
  - MULTU: unsigned 32×32 → 64.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - MADD/MADDU: `{HI,LO}` + the signed/unsigned product, modulo 2^64; uses HI/LO as sampled at start.
- **Divide by zero:** latency is the same as any divide; HI/LO are left unchanged at completion.
- **RUN:** the counter decrements each edge. On the edge where it goes 1 → 0, HI/LO take the pending result and `Busy` drops.
- **MTHI/MTLO in IDLE, `!Req`:** HI or LO ← `E_rs_data` on the next edge; no busy period.
- **Ops arriving while `Busy` = 1:** start-class ops, MTHI and MTLO are ignored; Decode guarantees this never happens. MFHI/MFLO still read the current, old HI/LO.
- **`Req` = 1:** blocks start and MTHI/MTLO for that cycle. It does not abort an operation already in RUN, because that instruction has already passed the commit point.
- **Reset** (asynchronous, any time, including mid-RUN): counter = 0, `Busy` = 0, HI = 0, LO = 0, pending result = 0.

## Timing
- Reset values: `Busy` = 0, `HI` = 0, `LO` = 0. `Start` and `E_MDU_out` follow their inputs combinationally; with `MDUOp` = 0 both are 0.
- **Start accepted at edge k:**
  - `Busy` = 1 from just after edge k until just after edge k+N, i.e. N cycles, where N is the op's cycle parameter.
  - HI/LO show the new value from edge k+N.
  - A new start is possible in the cycle following edge k+N.
- Decode stalls any MFHI/MFLO/MTHI/MTLO/start op while `Start || Busy`.
- MTHI/MTLO take one cycle; an MFHI issued in the next cycle reads the written value.
- The counter is 4 bits, so `MULT_CYCLES` and `DIV_CYCLES` must each be in 1..15.

## Configuration
- `MDU_MADD_EN` defined: ops 9 (MADD) and 10 (MADDU) are decoded as start-class, with `MULT_CYCLES` latency and accumulate semantics.
- `MDU_MADD_EN` undefined: ops 9 and 10 are treated as NONE. No start, no `Busy`, HI/LO untouched, and the accumulate adder is not synthesised.

## Test plan
- **Reset, then signed multiply:** MULT with rs = 0xFFFF_FFFE (−2), rt = 3.
  - `Busy` stays high exactly 5 cycles.
  - Then HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA.
- **Signed and unsigned divide:**
  - DIV with rs = −7 (0xFFFF_FFF9), rt = 2 → after 10 cycles LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
  - DIVU with the same operands → LO = 0x7FFF_FFFC, HI = 1.
- **Req blocks new work:**
  - MULTU with `Req` = 1 in the issue cycle → `Start` = 0, `Busy` stays 0, HI/LO unchanged.
  - Req rising mid-RUN → the operation still completes.
- **Move/read and divide by zero:**
  - MTLO 0x1234_5678, then MFLO next cycle → `E_MDU_out` = 0x1234_5678.
  - DIV with rt = 0 → `Busy` for 10 cycles, HI/LO unchanged.
- **Reset mid-operation:** `reset` pulsed during cycle 3 of a DIV → `Busy`, HI and LO are 0 immediately, and no later update occurs.
- **Accumulate, with `MDU_MADD_EN` defined:** HI:LO = 0:0xFFFF_FFFF, then MADDU with rs = 1, rt = 1 → HI = 1, LO = 0 after 5 cycles. With the macro undefined, the same op leaves HI:LO unchanged and `Busy` = 0.
